// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, parameter legality checks
// and the parity helper used by both the rx and tx engines.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    localparam int MIN_DATA_BITS  = 5;
    localparam int MAX_DATA_BITS  = 9;
    localparam int MIN_OVERSAMPLE = 4;
    localparam int MAX_OVERSAMPLE = 32;

    function automatic logic data_bits_ok(input int n);
        return (n >= MIN_DATA_BITS) && (n <= MAX_DATA_BITS);
    endfunction

    function automatic logic oversample_ok(input int os);
        return (os >= MIN_OVERSAMPLE) && (os <= MAX_OVERSAMPLE) && ((os % 2) == 0);
    endfunction

    // Expected parity bit for a payload; narrower payloads are zero-extended.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input that idles high.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start detection with glitch rejection,
// mid-bit sampling, optional parity, 1/2 stop bits, valid/ready output.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    if (!data_bits_ok(DATA_BITS) || !oversample_ok(OVERSAMPLE) ||
        !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_param
        $error("uart_rx_core: illegal DATA_BITS/OVERSAMPLE/STOP_BITS");
    end

    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY_ODD != 0);

    logic                 rx_s;
    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_bad;
    logic                 par_bad;
    logic                 drop;
    logic                 complete;
    logic                 out_free;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        complete = baud_tick && (state == RX_STOP) && (tick_cnt == TICK_LAST) &&
                   (bit_cnt == STOP_LAST);
        out_free = !rx_valid || rx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
            par_bad  <= 1'b0;
            busy     <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                // Half a bit after the falling edge the line must still be low.
                RX_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= RX_DATA;
                            bit_cnt  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        par_bad  <= (parity_of(MAX_DATA_BITS'(shreg), PAR_ODD) != rx_s);
                        state    <= RX_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                // A low final stop bit parks in WAIT_IDLE so a break cannot retrigger.
                RX_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (!rx_s) stop_bad <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= rx_s ? RX_IDLE : RX_WAIT_IDLE;
                            busy    <= !rx_s;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: a completed frame loads only when the slot is free,
    // otherwise it is dropped and reported with the next delivered frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            drop       <= 1'b0;
        end else if (complete && out_free) begin
            rx_data    <= shreg;
            frame_err  <= stop_bad | ~rx_s;
            parity_err <= (PARITY_EN != 0) ? par_bad : 1'b0;
            overrun    <= drop;
            drop       <= 1'b0;
            rx_valid   <= 1'b1;
        end else if (complete) begin
            drop <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b1;
    logic       rx_ready = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
    logic       rx_valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    int         vcyc_a = 0, xfer_a = 0, xfer_b = 0;
    bit         busy_seen_a = 0;
    logic [7:0] cap_data_a = '0, cap_data_b = '0;
    logic       cap_fe_a = 0, cap_pe_a = 0, cap_ov_a = 0, cap_fe_b = 0, cap_pe_b = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .busy(busy_b)
    );

    // Transfer monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (busy_a) busy_seen_a = 1'b1;
        if (rx_valid_a) vcyc_a = vcyc_a + 1;
        if (rx_valid_a && rx_ready) begin
            xfer_a     = xfer_a + 1;
            cap_data_a = rx_data_a;
            cap_fe_a   = frame_err_a;
            cap_pe_a   = parity_err_a;
            cap_ov_a   = overrun_a;
        end
        if (rx_valid_b && rx_ready) begin
            xfer_b     = xfer_b + 1;
            cap_data_b = rx_data_b;
            cap_fe_b   = frame_err_b;
            cap_pe_b   = parity_err_b;
        end
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                              input logic par_v, input logic stop_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (with_par) drive_bit(sel, par_v);
        drive_bit(sel, stop_v);
        if (stop_v) drive_bit(sel, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rx_valid_a !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid_a); else n_pass++;
        n_checks++; if (rx_data_a !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data_a); else n_pass++;
        n_checks++; if ({frame_err_a, parity_err_a, overrun_a} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {frame_err_a, parity_err_a, overrun_a}); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_8n1();
        int x0, v0;
        x0 = xfer_a; v0 = vcyc_a; busy_seen_a = 0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        n_checks++; if (xfer_a - x0 !== 1) $display("FAIL basic_xfers: got %0d expected 1", xfer_a - x0); else n_pass++;
        n_checks++; if (vcyc_a - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc_a - v0); else n_pass++;
        n_checks++; if (cap_data_a !== 8'hA5) $display("FAIL basic_data: got %h expected a5", cap_data_a); else n_pass++;
        n_checks++; if ({cap_fe_a, cap_pe_a, cap_ov_a} !== 3'b000)
            $display("FAIL basic_flags: got %b expected 000", {cap_fe_a, cap_pe_a, cap_ov_a}); else n_pass++;
        n_checks++; if (busy_seen_a !== 1'b1) $display("FAIL basic_busy_seen: got %b expected 1", busy_seen_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy_a); else n_pass++;
    endtask

    task automatic test_glitch();
        int x0;
        x0 = xfer_a; busy_seen_a = 0;
        rx_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (xfer_a - x0 !== 0) $display("FAIL glitch_no_frame: got %0d expected 0", xfer_a - x0); else n_pass++;
        n_checks++; if (busy_seen_a !== 1'b1) $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", busy_a); else n_pass++;
    endtask

    task automatic test_parity();
        int x0;
        x0 = xfer_b;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        n_checks++; if (xfer_b - x0 !== 1) $display("FAIL par_bad_xfer: got %0d expected 1", xfer_b - x0); else n_pass++;
        n_checks++; if (cap_data_b !== 8'h07) $display("FAIL par_bad_data: got %h expected 07", cap_data_b); else n_pass++;
        n_checks++; if (cap_pe_b !== 1'b1) $display("FAIL par_bad_flag: got %b expected 1", cap_pe_b); else n_pass++;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        n_checks++; if (xfer_b - x0 !== 2) $display("FAIL par_good_xfer: got %0d expected 2", xfer_b - x0); else n_pass++;
        n_checks++; if (cap_pe_b !== 1'b0) $display("FAIL par_good_flag: got %b expected 0", cap_pe_b); else n_pass++;
        n_checks++; if (cap_fe_b !== 1'b0) $display("FAIL par_good_fe: got %b expected 0", cap_fe_b); else n_pass++;
    endtask

    task automatic test_break();
        int x0;
        x0 = xfer_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (48) @(posedge clk);
        #1;
        n_checks++; if (xfer_a - x0 !== 1) $display("FAIL break_one_frame: got %0d expected 1", xfer_a - x0); else n_pass++;
        n_checks++; if (cap_data_a !== 8'h55) $display("FAIL break_data: got %h expected 55", cap_data_a); else n_pass++;
        n_checks++; if (cap_fe_a !== 1'b1) $display("FAIL break_frame_err: got %b expected 1", cap_fe_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL break_wait_busy: got %b expected 1", busy_a); else n_pass++;
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        n_checks++; if (xfer_a - x0 !== 2) $display("FAIL break_recover_xfer: got %0d expected 2", xfer_a - x0); else n_pass++;
        n_checks++; if (cap_data_a !== 8'h3C) $display("FAIL break_recover_data: got %h expected 3c", cap_data_a); else n_pass++;
        n_checks++; if (cap_fe_a !== 1'b0) $display("FAIL break_recover_fe: got %b expected 0", cap_fe_a); else n_pass++;
    endtask

    task automatic test_overrun();
        int x0;
        rx_ready = 1'b0;
        x0 = xfer_a;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rx_valid_a !== 1'b1) $display("FAIL ovr_held_valid: got %b expected 1", rx_valid_a); else n_pass++;
        n_checks++; if (rx_data_a !== 8'h11) $display("FAIL ovr_held_data: got %h expected 11", rx_data_a); else n_pass++;
        n_checks++; if (overrun_a !== 1'b0) $display("FAIL ovr_held_flag: got %b expected 0", overrun_a); else n_pass++;
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (xfer_a - x0 !== 1) $display("FAIL ovr_take_xfer: got %0d expected 1", xfer_a - x0); else n_pass++;
        n_checks++; if (rx_valid_a !== 1'b0) $display("FAIL ovr_take_drop_valid: got %b expected 0", rx_valid_a); else n_pass++;
        send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
        n_checks++; if (cap_data_a !== 8'h44) $display("FAIL ovr_next_data: got %h expected 44", cap_data_a); else n_pass++;
        n_checks++; if (cap_ov_a !== 1'b1) $display("FAIL ovr_next_flag: got %b expected 1", cap_ov_a); else n_pass++;
        send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
        n_checks++; if (cap_data_a !== 8'h66) $display("FAIL ovr_clear_data: got %h expected 66", cap_data_a); else n_pass++;
        n_checks++; if (cap_ov_a !== 1'b0) $display("FAIL ovr_clear_flag: got %b expected 0", cap_ov_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int v0, x0;
        logic [7:0] d;
        d = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i]);
        v0 = vcyc_a; x0 = xfer_a;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #1;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_a); else n_pass++;
        n_checks++; if (rx_data_a !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", rx_data_a); else n_pass++;
        n_checks++; if ({rx_valid_a, frame_err_a, parity_err_a, overrun_a} !== 4'b0000)
            $display("FAIL rstmid_flags: got %b expected 0000", {rx_valid_a, frame_err_a, parity_err_a, overrun_a}); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        n_checks++; if (vcyc_a - v0 !== 0) $display("FAIL rstmid_no_valid: got %0d expected 0", vcyc_a - v0); else n_pass++;
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        n_checks++; if (xfer_a - x0 !== 1) $display("FAIL rstmid_next_xfer: got %0d expected 1", xfer_a - x0); else n_pass++;
        n_checks++; if (cap_data_a !== 8'h81) $display("FAIL rstmid_next_data: got %h expected 81", cap_data_a); else n_pass++;
        n_checks++; if ({cap_fe_a, cap_ov_a} !== 2'b00)
            $display("FAIL rstmid_next_flags: got %b expected 00", {cap_fe_a, cap_ov_a}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine, next generation of the fixed 8-bit serial-in/parallel-out receive path. It synchronises the rx line, detects the start bit with oversampling and glitch rejection, and samples each bit at mid-bit. It assembles DATA_BITS bits LSB-first, with optional parity and 1 or 2 stop bits, and presents each frame on a valid/ready output with error flags. It sits between the pad-side rx line and the byte-level consumer (FIFO or register interface), driven by a shared baud-tick generator.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, 4..32)
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_tick  in  1  single-cycle enable at OVERSAMPLE x baud rate
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received payload, bit 0 = first bit on line
rx_valid  out  1  rx_data and flags hold a frame
rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready
frame_err  out  1  stop bit sampled 0 (qualified by rx_valid)
parity_err  out  1  parity mismatch (qualified by rx_valid; 0 if PARITY_EN=0)
overrun  out  1  one or more frames dropped before this one was taken
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: both synchroniser flops = 1; FSM = IDLE; tick counter, bit counter, shift reg = 0; rx_data = 0; rx_valid, frame_err, parity_err, overrun, busy = 0. Reset mid-frame aborts the frame with no output.
- rx passes through a 2-flop synchroniser; rx_s = synchronised line. All sampling happens only on cycles with baud_tick=1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: rx_s==0 on a tick -> START, tick_cnt=0.
- START: at tick_cnt==OVERSAMPLE/2-1, re-sample. rx_s==1 -> IDLE (glitch, no output). rx_s==0 -> DATA with tick_cnt=0, bit_cnt=0.
- DATA: every OVERSAMPLE ticks, sample rx_s into the shift reg (right shift, new bit enters at MSB, LSB-first). After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: one sample; par_bad = XOR(data, sample) != PARITY_ODD.
- STOP: samples STOP_BITS bits at mid-bit. Any 0 sampled -> frame_err for this frame. The frame completes on the final stop sample: go to IDLE if that sample was 1, else WAIT_IDLE.
- WAIT_IDLE: stays until rx_s==1 on a tick, then IDLE. This prevents a break condition from retriggering.
- Completion (clock with final stop sample), output register free (rx_valid==0, or rx_valid && rx_ready same cycle): load rx_data, frame_err, parity_err; rx_valid=1 next clock. overrun = pending drop flag; the drop flag clears.
- Completion with output register occupied and rx_ready==0: frame discarded; rx_data and flags unchanged; internal drop flag set (sticky until next successful load).
- Handshake: rx_valid holds until rx_valid && rx_ready. It then deasserts the next clock unless a load coincides; in that case rx_valid stays 1 with the new data.
- rx_data and flags are stable while rx_valid=1 and not accepted.
- Latency: rx_valid rises 1 clk after the baud_tick carrying the final stop sample. rx edge to first detection: 2 clk of synchroniser.
- busy = (state != IDLE).

Decomposition:
- Package uart_pkg: state enum for rx states; parity helper function (XOR-reduce with odd/even select); OVERSAMPLE/DATA_BITS legality checks as constants. The tx side shares the same package.
- Sub-module uart_sync2: 2-flop synchroniser with reset value 1 and asynchronous active-low reset. It is reused for other async inputs.

Test Plan:
- OVERSAMPLE=16, baud_tick every clk, frame 0xA5 with 8N1, rx_ready=1 -> rx_data=0xA5, rx_valid pulse 1 clk, all flags 0, busy falls after stop.
- rx low for 4 ticks then high (glitch) -> FSM returns IDLE, no rx_valid, busy pulse only.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong) -> rx_data=0x07, parity_err=1. Same frame with parity 1 -> parity_err=0.
- Stop bit driven 0 then line held low 3 bit-times -> frame_err=1 on 0x?? frame; no new frame until rx returns high, then next 0x3C received clean.
- rx_ready=0, send 0x11, 0x22, 0x33 -> rx_data stays 0x11. Assert rx_ready, then send 0x44 -> 0x44 delivered with overrun=1. Next frame has overrun=0.
- Assert rst_n=0 mid-DATA of 0x5A -> all outputs 0, rx_valid never asserts. Following full frame 0x81 received correctly.
